sensor_conditioner: RTL
=======================

Name: sensor_conditioner

Overview:
- Front-end stage ahead of load_size, water_level and detergent_level.
- Samples three raw 8-bit sensor inputs at a divided rate and applies a per-channel moving average over 2^AVG_LOG2 samples.
- Drives the filtered values into the classifier inputs (load_sensor, water_sensor, detergent_sensor).
- Provides a data-valid flag, a per-sample strobe and sticky per-channel sensor-fault flags for cycle_control.

Parameters:
- SAMPLE_DIV, 4: clock cycles per sample tick; legal range 2..256.
- AVG_LOG2, 2: log2 of averaging window depth; legal range 1..4 (window 2..16).
- FAULT_RUN, 3: consecutive out-of-range samples needed to set a fault; legal range 1..7.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: reset, asynchronous assert, active-low (0 = reset). Release is synchronised by the system reset tree.
- hold, input, 1: 1 = freeze sampling; divider, window and outputs are retained.
- clear_fault, input, 1: 1-cycle pulse that clears all fault flags and run counters.
- load_raw, input, 8: raw load sensor.
- water_raw, input, 8: raw water sensor.
- det_raw, input, 8: raw detergent sensor.
- load_sensor, output, 8: filtered load value.
- water_sensor, output, 8: filtered water value.
- detergent_sensor, output, 8: filtered detergent value.
- data_valid, output, 1: 1 once the averaging window is full.
- sample_strobe, output, 1: 1-cycle pulse, high in the cycle after each absorbed sample.
- sensor_fault, output, 3: sticky fault flags; bit0 = load, bit1 = water, bit2 = detergent.

Behaviour:
- Reset (rst = 0): all of the following clear immediately, independent of clk:
  - outputs, data_valid, sample_strobe and sensor_fault go to 0;
  - window registers, sums, divider, fill counter and run counters go to 0;
  - the FSM goes to FILL.
- Divider:
  - div_cnt counts 0..SAMPLE_DIV-1 while hold = 0, then wraps to 0.
  - A tick occurs on the edge where div_cnt = SAMPLE_DIV-1.
  - After reset release, the first tick is the SAMPLE_DIV-th rising edge.
- On a tick, each channel is processed on the same edge:
  - shift the raw value into the window;
  - sum_next = sum + new - oldest (evicted);
  - output = sum_next >> AVG_LOG2.
- Latency: output registers update on the tick edge; sample_strobe is high for the following cycle.
- Arithmetic:
  - sum width is 8 + AVG_LOG2 bits, so overflow is impossible;
  - the divide is floor truncation;
  - the zero-initialised window means averages ramp up during FILL.
- FSM FILL:
  - fill_cnt increments per tick;
  - on the 2^AVG_LOG2-th tick, data_valid is set on the same edge and the FSM moves to RUN.
- FSM RUN:
  - data_valid stays 1 until reset;
  - there is no return to FILL.
- hold:
  - hold = 1 in the cycle a tick would occur suppresses that tick; div_cnt does not advance.
  - On hold release, counting resumes from the retained div_cnt.
- Fault detection:
  - A sample equal to 8'h00 or 8'hFF is out-of-range; a 3-bit run counter increments, saturating at FAULT_RUN.
  - Any in-range sample zeroes that channel's run counter.
  - When the counter reaches FAULT_RUN, the fault bit sets on that tick edge.
  - Out-of-range samples are still absorbed into the average.
- Fault clear:
  - Fault bits are sticky until clear_fault.
  - clear_fault on a tick edge has priority: bits and counters are cleared, and that sample does not count toward the run.
- Reset mid-operation: full return to the reset state, including FILL and data_valid = 0.

Decomposition:
- Package sensor_pkg holds:
  - the sensor data width constant (8);
  - channel indices (LOAD = 0, WATER = 1, DET = 2);
  - out-of-range code constants (8'h00, 8'hFF);
  - the FSM enum {FILL, RUN}.
- One sub-module, sensor_avg_channel, instantiated three times. It contains:
  - the window shift register;
  - the running sum;
  - the output register;
  - the fault run counter and sticky flag.
- The top level holds the divider, the FSM and fill counter, and sample_strobe.

Test Plan:
- Reset then constant raw = 100 on all channels: strobes every 4 cycles; outputs 25, 50, 75, 100; data_valid rises with the 4th update; outputs remain 100 thereafter.
- In RUN, step load_raw 100 → 200: load_sensor 125, 150, 175, 200 on successive ticks; other channels stay 100.
- Apply window samples 3, 4, 4, 4: output = 3 (floor of 15/4). Then assert hold for 10 cycles: no strobe, outputs and div_cnt frozen; first tick comes SAMPLE_DIV - div_cnt cycles after release.
- water_raw = 255 for 3 ticks: sensor_fault = 3'b010 on the 3rd tick; raw 255, 255, 0x10, 255 does not set the fault. clear_fault drops the bit to 0; a further 3 bad ticks set it again.
- Assert rst low mid-RUN, between clock edges: all outputs, data_valid and sensor_fault are 0 before the next edge. After release, FILL restarts with ramp 25, 50, 75, 100.
- clear_fault coincident with the 3rd out-of-range tick: fault stays 0 and the run counter is 0.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared constants, channel indices and state encoding for the sensor conditioning front end.
package sensor_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned RUN_W    = 3;

    localparam int unsigned CH_LOAD  = 0;
    localparam int unsigned CH_WATER = 1;
    localparam int unsigned CH_DET   = 2;

    localparam logic [DATA_W-1:0] OOR_LO = 8'h00;
    localparam logic [DATA_W-1:0] OOR_HI = 8'hFF;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } cond_state_e;

    // A rail-stuck reading (all zeros or all ones) is treated as a broken sensor.
    function automatic logic is_out_of_range(input logic [DATA_W-1:0] sample);
        return (sample == OOR_LO) || (sample == OOR_HI);
    endfunction

endpackage

// File: rtl/sensor_avg_channel.sv
// One sensor channel: moving-average window with running sum, plus sticky
// fault detection on consecutive rail-stuck samples.
module sensor_avg_channel
    import sensor_pkg::*;
#(
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned FAULT_RUN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              clear_fault,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] avg,
    output logic              fault
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0] window [DEPTH];
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic [RUN_W-1:0]  run_cnt;
    logic [RUN_W-1:0]  run_next;

    // Sum always contains the oldest sample, so the subtraction never underflows.
    always_comb begin
        sum_next = sum + SUM_W'(raw) - SUM_W'(window[DEPTH-1]);
        run_next = '0;
        if (is_out_of_range(raw)) begin
            run_next = (run_cnt >= RUN_W'(FAULT_RUN)) ? run_cnt : run_cnt + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                window[i] <= '0;
            end
            sum <= '0;
            avg <= '0;
        end else if (tick) begin
            window[0] <= raw;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                window[i] <= window[i-1];
            end
            sum <= sum_next;
            avg <= sum_next[SUM_W-1:AVG_LOG2];
        end
    end

    // Clearing wins over a coincident tick; that sample is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            fault   <= 1'b0;
        end else if (clear_fault) begin
            run_cnt <= '0;
            fault   <= 1'b0;
        end else if (tick) begin
            run_cnt <= run_next;
            if (run_next == RUN_W'(FAULT_RUN)) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: divided-rate sampling of three raw sensors into moving-average
// filters, with window-fill tracking, a per-sample strobe and sticky fault flags.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned FAULT_RUN  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              clear_fault,
    input  logic [DATA_W-1:0] load_raw,
    input  logic [DATA_W-1:0] water_raw,
    input  logic [DATA_W-1:0] det_raw,
    output logic [DATA_W-1:0] load_sensor,
    output logic [DATA_W-1:0] water_sensor,
    output logic [DATA_W-1:0] detergent_sensor,
    output logic              data_valid,
    output logic              sample_strobe,
    output logic [NUM_CH-1:0] sensor_fault
);

    localparam int unsigned DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned FILL_W = AVG_LOG2;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick_c;
    cond_state_e       state;
    cond_state_e       state_d;
    logic [FILL_W-1:0] fill_cnt;
    logic [FILL_W-1:0] fill_cnt_d;
    logic              data_valid_d;

    assign tick_c = !hold && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Sample-rate divider; frozen while hold is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!hold) begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FILL;
            fill_cnt      <= '0;
            data_valid    <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            state         <= state_d;
            fill_cnt      <= fill_cnt_d;
            data_valid    <= data_valid_d;
            sample_strobe <= tick_c;
        end
    end

    // Window-fill tracking: valid once every window slot holds a real sample.
    always_comb begin
        state_d      = state;
        fill_cnt_d   = fill_cnt;
        data_valid_d = data_valid;
        case (state)
            FILL: begin
                if (tick_c) begin
                    if (fill_cnt == FILL_W'(DEPTH - 1)) begin
                        state_d      = RUN;
                        data_valid_d = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt + FILL_W'(1);
                    end
                end
            end
            RUN: begin
                data_valid_d = 1'b1;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    sensor_avg_channel #(
        .AVG_LOG2  (AVG_LOG2),
        .FAULT_RUN (FAULT_RUN)
    ) u_load (
        .clk         (clk),
        .rst_n       (rst),
        .tick        (tick_c),
        .clear_fault (clear_fault),
        .raw         (load_raw),
        .avg         (load_sensor),
        .fault       (sensor_fault[CH_LOAD])
    );

    sensor_avg_channel #(
        .AVG_LOG2  (AVG_LOG2),
        .FAULT_RUN (FAULT_RUN)
    ) u_water (
        .clk         (clk),
        .rst_n       (rst),
        .tick        (tick_c),
        .clear_fault (clear_fault),
        .raw         (water_raw),
        .avg         (water_sensor),
        .fault       (sensor_fault[CH_WATER])
    );

    sensor_avg_channel #(
        .AVG_LOG2  (AVG_LOG2),
        .FAULT_RUN (FAULT_RUN)
    ) u_det (
        .clk         (clk),
        .rst_n       (rst),
        .tick        (tick_c),
        .clear_fault (clear_fault),
        .raw         (det_raw),
        .avg         (detergent_sensor),
        .fault       (sensor_fault[CH_DET])
    );

endmodule
